// File: rtl/sound_event_tx.sv
// Game-event to sound-command transmitter: edge-detects raw event levels, pends and
// arbitrates them into a small FIFO, and strobes bytes out over txdata/txclk/txready.
module sound_event_tx #(
  parameter int DEPTH = 4,
  parameter int GAP   = 3,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          goodColl,
  input  logic          badColl,
  input  logic          toggleMode,
  input  logic [3:0]    direction,
  input  logic          txready,
  output logic [7:0]    txdata,
  output logic          txclk,
  output logic [CW-1:0] count,
  output logic          muted,
  output logic          overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_V = GW'(GAP);
  localparam logic [GW-1:0] ONE   = GW'(1);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT} state_t;

  state_t        state_q, state_d;
  logic          good_prev_q, bad_prev_q, tog_prev_q;
  logic [3:0]    dir_prev_q;
  logic          pend_g_q, pend_b_q, pend_t_q, pend_d_q;
  logic          pend_g_d, pend_b_d, pend_t_d, pend_d_d;
  logic [3:0]    dir_lat_q, dir_lat_d;
  logic          muted_q, muted_d, ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    txdata_q, txdata_d;
  logic          txclk_q, txclk_d;
  logic [GW-1:0] gap_q, gap_d;

  logic e_g, e_b, e_t, e_d;
  logic push, pop, push_g, push_b, push_t, push_d;
  logic [7:0] push_byte;

  // Muted mode suppresses G/B/D at the edge detector so they neither pend nor overflow.
  assign e_g = goodColl & ~good_prev_q & ~muted_q;
  assign e_b = badColl & ~bad_prev_q & ~muted_q;
  assign e_t = toggleMode & ~tog_prev_q;
  assign e_d = (|(direction & ~dir_prev_q)) & ~muted_q;

  assign push   = (pend_b_q | pend_g_q | pend_t_q | pend_d_q) & (count_q != FULL);
  assign push_b = push & pend_b_q;
  assign push_g = push & ~pend_b_q & pend_g_q;
  assign push_t = push & ~pend_b_q & ~pend_g_q & pend_t_q;
  assign push_d = push & ~pend_b_q & ~pend_g_q & ~pend_t_q & pend_d_q;
  assign pop    = (state_q == IDLE) && (count_q != '0) && txready;

  always_comb begin
    push_byte = 8'h00;
    if (push_b)      push_byte = 8'h20;
    else if (push_g) push_byte = 8'h10;
    else if (push_t) push_byte = 8'h30;
    else if (push_d) push_byte = {4'h4, dir_lat_q};
  end

  // A new edge re-arms its pending bit even when the old one is being enqueued; only a
  // still-waiting event is lost, which is what overflow records.
  always_comb begin
    pend_g_d  = (pend_g_q & ~push_g) | e_g;
    pend_b_d  = (pend_b_q & ~push_b) | e_b;
    pend_t_d  = (pend_t_q & ~push_t) | e_t;
    pend_d_d  = (pend_d_q & ~push_d) | e_d;
    dir_lat_d = e_d ? direction : dir_lat_q;
    muted_d   = muted_q ^ e_t;
    ovf_d     = ovf_q | (e_g & pend_g_q & ~push_g) | (e_b & pend_b_q & ~push_b)
                      | (e_t & pend_t_q & ~push_t) | (e_d & pend_d_q & ~push_d);
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    txdata_d = txdata_q;
    txclk_d  = 1'b0;
    gap_d    = gap_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          txdata_d = mem_q[rd_ptr_q];
          state_d  = STROBE;
        end
      end
      STROBE: begin
        txclk_d = 1'b1;
        gap_d   = GAP_V;
        state_d = WAIT;
      end
      WAIT: begin
        if (gap_q <= ONE) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= IDLE;
      good_prev_q <= 1'b0;
      bad_prev_q  <= 1'b0;
      tog_prev_q  <= 1'b0;
      dir_prev_q  <= '0;
      pend_g_q    <= 1'b0;
      pend_b_q    <= 1'b0;
      pend_t_q    <= 1'b0;
      pend_d_q    <= 1'b0;
      dir_lat_q   <= '0;
      muted_q     <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      txdata_q    <= '0;
      txclk_q     <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      good_prev_q <= goodColl;
      bad_prev_q  <= badColl;
      tog_prev_q  <= toggleMode;
      dir_prev_q  <= direction;
      pend_g_q    <= pend_g_d;
      pend_b_q    <= pend_b_d;
      pend_t_q    <= pend_t_d;
      pend_d_q    <= pend_d_d;
      dir_lat_q   <= dir_lat_d;
      muted_q     <= muted_d;
      ovf_q       <= ovf_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      txdata_q    <= txdata_d;
      txclk_q     <= txclk_d;
      gap_q       <= gap_d;
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_byte;
  end

  assign txdata   = txdata_q;
  assign txclk    = txclk_q;
  assign count    = count_q;
  assign muted    = muted_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sound_event_tx.sv
// Directed bench for sound_event_tx: drives event levels and checks bytes, strobe timing,
// FIFO backpressure, mute handling and reset abort against hand-computed values.
module tb_sound_event_tx;

  logic       clk = 1'b0;
  logic       nRst, goodColl, badColl, toggleMode, txready;
  logic [3:0] direction;
  logic [7:0] txdata;
  logic       txclk;
  logic [2:0] count;
  logic       muted, overflow;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [7:0] log_b [$];
  int         log_t [$];

  sound_event_tx #(.DEPTH(4), .GAP(3)) dut (
    .clk(clk), .nRst(nRst), .goodColl(goodColl), .badColl(badColl),
    .toggleMode(toggleMode), .direction(direction), .txready(txready),
    .txdata(txdata), .txclk(txclk), .count(count), .muted(muted), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every strobed byte is logged with the number of the edge that raised txclk.
  always @(negedge clk) begin
    if (nRst && txclk) begin
      log_b.push_back(txdata);
      log_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int byte_at(input int i);
    return (i < log_b.size()) ? int'(log_b[i]) : -1;
  endfunction

  function automatic int time_at(input int i);
    return (i < log_t.size()) ? log_t[i] : -1000;
  endfunction

  task automatic clear_log();
    log_b.delete();
    log_t.delete();
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    goodColl = 1'b0; badColl = 1'b0; toggleMode = 1'b0; direction = 4'h0;
    step(2);
    nRst = 1'b1;
    step(1);
  endtask

  initial begin
    nRst = 1'b0; goodColl = 1'b0; badColl = 1'b0; toggleMode = 1'b0;
    direction = 4'h0; txready = 1'b1;
    step(2);
    check("rst_txdata", txdata, 0);
    check("rst_txclk", txclk, 0);
    check("rst_count", count, 0);
    check("rst_muted", muted, 0);
    check("rst_overflow", overflow, 0);
    nRst = 1'b1;
    step(2);

    // single good collision: pend at k, push k+1, pop k+2, strobe k+3
    goodColl = 1'b1;
    step(1);
    check("t1_cnt_k", count, 0);
    step(1);
    check("t1_cnt_k1", count, 1);
    step(1);
    check("t1_data_k2", txdata, 8'h10);
    check("t1_clk_k2", txclk, 0);
    check("t1_cnt_k2", count, 0);
    step(1);
    check("t1_clk_k3", txclk, 1);
    check("t1_data_k3", txdata, 8'h10);
    step(1);
    check("t1_clk_k4", txclk, 0);
    check("t1_data_k4", txdata, 8'h10);
    goodColl = 1'b0;
    step(5);
    check("t1_nbytes", log_b.size(), 1);

    // simultaneous bad + good
    clear_log();
    goodColl = 1'b1; badColl = 1'b1;
    step(1);
    goodColl = 1'b0; badColl = 1'b0;
    step(15);
    check("t2_nbytes", log_b.size(), 2);
    check("t2_byte0", byte_at(0), 8'h20);
    check("t2_byte1", byte_at(1), 8'h10);
    check("t2_spacing", time_at(1) - time_at(0), 5);
    check("t2_overflow", overflow, 0);
    check("t2_count", count, 0);

    // direction edges
    clear_log();
    direction = 4'b0100;
    step(12);
    check("t3_nbytes_a", log_b.size(), 1);
    check("t3_byte0", byte_at(0), 8'h44);
    step(12);
    check("t3_hold", log_b.size(), 1);
    direction = 4'b0110;
    step(12);
    check("t3_nbytes_b", log_b.size(), 2);
    check("t3_byte1", byte_at(1), 8'h46);

    // backpressure with all four types, then toggle overflow
    clear_log();
    txready = 1'b0;
    badColl = 1'b1; goodColl = 1'b1; toggleMode = 1'b1; direction = 4'b1000;
    step(1);
    check("t4_muted_on", muted, 1);
    step(4);
    check("t4_full", count, 4);
    check("t4_ovf0", overflow, 0);
    badColl = 1'b0; goodColl = 1'b0; toggleMode = 1'b0;
    step(1);
    toggleMode = 1'b1;
    step(1);
    check("t4_muted_off", muted, 0);
    step(2);
    check("t4_full_hold", count, 4);
    toggleMode = 1'b0;
    step(1);
    toggleMode = 1'b1;
    step(1);
    check("t4_ovf1", overflow, 1);
    check("t4_muted_on2", muted, 1);
    check("t4_cnt_still", count, 4);
    toggleMode = 1'b0;
    check("t4_no_tx", log_b.size(), 0);
    txready = 1'b1;
    step(40);
    check("t4_nbytes", log_b.size(), 5);
    check("t4_b0", byte_at(0), 8'h20);
    check("t4_b1", byte_at(1), 8'h10);
    check("t4_b2", byte_at(2), 8'h30);
    check("t4_b3", byte_at(3), 8'h48);
    check("t4_b4", byte_at(4), 8'h30);
    check("t4_drained", count, 0);

    // mute suppresses G but still sends T
    do_reset();
    check("t5_rst_muted", muted, 0);
    check("t5_rst_ovf", overflow, 0);
    clear_log();
    toggleMode = 1'b1;
    step(1);
    check("t5_muted", muted, 1);
    toggleMode = 1'b0;
    step(10);
    check("t5_nbytes_a", log_b.size(), 1);
    check("t5_byte0", byte_at(0), 8'h30);
    goodColl = 1'b1;
    step(1);
    goodColl = 1'b0;
    step(1);
    check("t5_g_cnt", count, 0);
    step(10);
    check("t5_g_nobyte", log_b.size(), 1);
    check("t5_g_ovf", overflow, 0);
    toggleMode = 1'b1;
    step(1);
    check("t5_unmuted", muted, 0);
    toggleMode = 1'b0;
    step(10);
    check("t5_nbytes_b", log_b.size(), 2);
    check("t5_byte1", byte_at(1), 8'h30);

    // reset while a byte is being strobed
    txready = 1'b0;
    goodColl = 1'b1; badColl = 1'b1;
    step(1);
    goodColl = 1'b0; badColl = 1'b0;
    step(3);
    check("t6_queued", count, 2);
    txready = 1'b1;
    step(2);
    check("t6_strobe", txclk, 1);
    nRst = 1'b0;
    #1;
    check("t6_rst_txclk", txclk, 0);
    check("t6_rst_txdata", txdata, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_muted", muted, 0);
    check("t6_rst_ovf", overflow, 0);
    step(1);
    nRst = 1'b1;
    clear_log();
    step(20);
    check("t6_silent", log_b.size(), 0);
    check("t6_count", count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sound_event_tx.md
Name: sound_event_tx

Overview:
Transmit-side counterpart of the sound engine. It turns raw game-event levels (good collision, bad collision, mode toggle, direction buttons) into one-byte sound commands. Commands are buffered in a small FIFO and sent over the byte-wide txdata/txclk/txready strobe interface to a remote sound board. The block tracks the same ON/OFF mute mode as the sound engine so that muted events are never transmitted.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
GAP, 3, idle cycles enforced after each txclk strobe before the next byte can start
CW, $clog2(DEPTH)+1, width of the occupancy count (derived)

Ports:
clk  in  1  system clock
nRst  in  1  asynchronous active-low reset
goodColl  in  1  raw level, good-collision event
badColl  in  1  raw level, bad-collision event
toggleMode  in  1  raw level, mute-toggle button
direction  in  4  raw level, direction buttons
txready  in  1  downstream can accept a byte
txdata  out  8  command byte
txclk  out  1  one-cycle strobe, txdata valid
count  out  CW  FIFO occupancy
muted  out  1  1 = mode OFF
overflow  out  1  sticky, an event was coalesced (lost)

Behaviour:
- Reset, asynchronous: txdata=0, txclk=0, count=0, muted=0, overflow=0, all pending bits=0, FSM=IDLE, edge-history registers=0. Asserting reset mid-transfer aborts the transfer immediately and discards the FIFO.
- Edge detect: registered previous value per input.
  - Events on goodColl, badColl and toggleMode: input high and prev low.
  - Direction event: any bit of (direction & ~prev_direction) set; the captured vector is the current direction.
- Pending bits, one per type (G, B, T, D):
  - An edge sets the pending bit on the same clock edge it is detected. D also latches the direction vector, and the latest vector wins.
  - An edge on a type whose pending bit is already set sets overflow=1. overflow clears only on reset.
  - While muted=1, G/B/D edges are ignored: nothing is pended and overflow is unaffected. T is never ignored.
- Mode: each T edge toggles muted on the same edge it is detected.
- Arbiter: at most one enqueue per cycle, and only when count<DEPTH, using the registered count.
  - Priority B > G > T > D. The enqueued pending bit clears.
  - When the FIFO is full, pending bits hold. This is backpressure, not loss.
  - No push while full, even if a pop occurs in the same cycle.
- Encoding:
  - B = 8'h20, G = 8'h10, T = 8'h30.
  - D = {4'h4, latched direction}.
- FIFO: circular with wrapping pointers. Push and pop in the same cycle leaves count unchanged. There is no bypass: the FSM sees a byte the cycle after it is written.
- TX FSM:
  - IDLE: if count>0 and txready=1, pop; txdata<=head; go to STROBE.
  - STROBE: txclk<=1; load gap counter with GAP; go to WAIT.
  - WAIT: txclk<=0; decrement the counter; when it reaches 0, go to IDLE.
  - txdata holds its value from the pop through the end of WAIT and until the next pop.
  - txready is sampled only in IDLE. Dropping it later does not cancel the byte in flight.
- Latency, empty FIFO with txready=1:
  - The input is first high at edge k, so pending is set at k.
  - Push at k+1.
  - Pop and txdata at k+2.
  - txclk high for the cycle after edge k+3, low from k+4.
  - Minimum byte spacing is 2+GAP cycles between txclk rising edges.

Test Plan:
1. goodColl pulse, txready=1, empty FIFO -> txdata=8'h10 one cycle before txclk; txclk high exactly one cycle, 3 edges after capture; count returns to 0.
2. goodColl and badColl rise in the same cycle -> bytes 8'h20 then 8'h10, with txclk rising edges 5 cycles apart (GAP=3); overflow stays 0.
3. direction goes 0000->0100 -> byte 8'h44. Holding the level produces no further byte. Then 0100->0110 -> byte 8'h46.
4. Hold txready=0, then fire B, G, T, D edges -> count=4; muted ends at 1.
   - Toggle again (pended, count stays 4, muted=0); toggle once more -> overflow=1, muted=1.
   - Raise txready -> bytes 8'h20, 8'h10, 8'h30, {8'h4x}, then 8'h30, in that order.
5. toggleMode edge -> byte 8'h30, muted=1. goodColl edge -> no byte, count stays 0, overflow 0. toggleMode edge -> 8'h30, muted=0.
6. Assert nRst during the STROBE cycle with 2 entries queued -> txclk falls immediately; txdata=0, count=0, muted=0, overflow=0. After release, no bytes are sent until a new event.
